// File: rtl/serial_adder.sv
// serial_adder: multi-cycle adder that adds CHUNK bits of two WIDTH-bit operands
// per clock, with a valid/ready handshake on both the operand and result sides.
// Optional feature: define SERIAL_ADDER_OVF_EN to add the two's-complement
// overflow output 'ovf'.
module serial_adder #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned CHUNK = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             ci,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             co,
   output logic             busy
`ifdef SERIAL_ADDER_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int unsigned NCHUNK = WIDTH / CHUNK;
   localparam int unsigned CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam int unsigned OW     = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   if ((WIDTH % CHUNK) != 0 || CHUNK == 0) begin : g_bad_params
      $error("serial_adder: WIDTH must be a non-zero multiple of CHUNK");
   end

   typedef enum logic [1:0] {
      IDLE,
      ADD,
      DONE
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic             carry_q, carry_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             co_q, co_d;
`ifdef SERIAL_ADDER_OVF_EN
   logic             ovf_q, ovf_d;
   logic             carry_into_msb;
`endif

   logic [OW-1:0]    off;
   logic [CHUNK-1:0] a_chunk;
   logic [CHUNK-1:0] b_chunk;
   logic [CHUNK:0]   chunk_sum;
   logic             last_chunk;

   // State register: async reset discards any in-flight operation
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic: IDLE -> ADD on accept, ADD -> DONE on last chunk,
   // DONE -> IDLE when the result is taken
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (in_valid)   state_d = ADD;
         ADD:     if (last_chunk) state_d = DONE;
         DONE:    if (out_ready)  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Output decode straight from the state register
   always_comb begin
      in_ready  = (state_q == IDLE);
      out_valid = (state_q == DONE);
      busy      = (state_q == ADD);
      sum       = sum_q;
      co        = co_q;
`ifdef SERIAL_ADDER_OVF_EN
      ovf       = ovf_q;
`endif
   end

   // Chunk slice selection and the CHUNK-bit add for the current count
   always_comb begin
      off        = OW'(cnt_q) * OW'(CHUNK);
      a_chunk    = a_q[off +: CHUNK];
      b_chunk    = b_q[off +: CHUNK];
      chunk_sum  = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry_q};
      last_chunk = (cnt_q == CW'(NCHUNK - 1));
`ifdef SERIAL_ADDER_OVF_EN
      // sum bit = a ^ b ^ carry-in, so the carry into the MSB is recovered from it
      carry_into_msb = chunk_sum[CHUNK-1] ^ a_chunk[CHUNK-1] ^ b_chunk[CHUNK-1];
`endif
   end

   // Datapath next values: capture on accept, accumulate chunks in ADD, hold otherwise
   always_comb begin
      a_d     = a_q;
      b_d     = b_q;
      carry_d = carry_q;
      cnt_d   = cnt_q;
      sum_d   = sum_q;
      co_d    = co_q;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_d   = ovf_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (in_valid) begin
               a_d     = a;
               b_d     = b;
               carry_d = ci;
               cnt_d   = '0;
            end
         end
         ADD: begin
            sum_d[off +: CHUNK] = chunk_sum[CHUNK-1:0];
            carry_d             = chunk_sum[CHUNK];
            if (last_chunk) begin
               cnt_d = '0;
               co_d  = chunk_sum[CHUNK];
`ifdef SERIAL_ADDER_OVF_EN
               ovf_d = carry_into_msb ^ chunk_sum[CHUNK];
`endif
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: ;
      endcase
   end

   // Datapath registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_q     <= '0;
         b_q     <= '0;
         carry_q <= 1'b0;
         cnt_q   <= '0;
         sum_q   <= '0;
         co_q    <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
         ovf_q   <= 1'b0;
`endif
      end else begin
         a_q     <= a_d;
         b_q     <= b_d;
         carry_q <= carry_d;
         cnt_q   <= cnt_d;
         sum_q   <= sum_d;
         co_q    <= co_d;
`ifdef SERIAL_ADDER_OVF_EN
         ovf_q   <= ovf_d;
`endif
      end
   end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: default 16/4 instance plus an 8/8
// single-chunk instance, checked against plain-arithmetic expected results.
module tb_serial_adder;

   localparam int unsigned NCHUNK = 4;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, in_valid, in_ready, ci, out_valid, out_ready, co, busy;
   logic [15:0] a, b, sum;
`ifdef SERIAL_ADDER_OVF_EN
   logic        ovf;
`endif

   logic        in_valid2, in_ready2, ci2, out_valid2, out_ready2, co2, busy2;
   logic [7:0]  a2, b2, sum2;
`ifdef SERIAL_ADDER_OVF_EN
   logic        ovf2;
`endif

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;

   serial_adder #(.WIDTH(16), .CHUNK(4)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .ci(ci), .out_valid(out_valid), .out_ready(out_ready),
      .sum(sum), .co(co), .busy(busy)
`ifdef SERIAL_ADDER_OVF_EN
      , .ovf(ovf)
`endif
   );

   serial_adder #(.WIDTH(8), .CHUNK(8)) dut8 (
      .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2),
      .a(a2), .b(b2), .ci(ci2), .out_valid(out_valid2), .out_ready(out_ready2),
      .sum(sum2), .co(co2), .busy(busy2)
`ifdef SERIAL_ADDER_OVF_EN
      , .ovf(ovf2)
`endif
   );

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // One full transaction on the 16-bit instance; operands are scrambled and
   // in_valid toggled while the add is in progress to prove they are ignored.
   task automatic run_op(input logic [15:0] ta, input logic [15:0] tb, input logic tci,
                         input int unsigned hold);
      logic [16:0] full;
      logic [15:0] es;
      logic        eco, eovf;
      int unsigned k;
      full = {1'b0, ta} + {1'b0, tb} + {16'd0, tci};
      es   = full[15:0];
      eco  = full[16];
      eovf = (ta[15] == tb[15]) && (es[15] != ta[15]);
      k = 0;
      while (!in_ready && k < 20) begin
         @(negedge clk);
         k++;
      end
      check_eq("in_ready_idle", in_ready, 1'b1);
      in_valid  = 1'b1;
      a         = ta;
      b         = tb;
      ci        = tci;
      out_ready = 1'b0;
      @(negedge clk);
      k = 0;
      while (!out_valid && k < 50) begin
         check_eq("in_ready_low_add", in_ready, 1'b0);
         check_eq("busy_add", busy, 1'b1);
         in_valid = 1'($urandom_range(0, 1));
         a        = 16'($urandom);
         b        = 16'($urandom);
         ci       = 1'($urandom);
         @(negedge clk);
         k++;
      end
      in_valid = 1'b0;
      check_eq("latency", k, NCHUNK);
      check_eq("sum", sum, es);
      check_eq("co", co, eco);
`ifdef SERIAL_ADDER_OVF_EN
      check_eq("ovf", ovf, eovf);
`endif
      for (int unsigned i = 0; i < hold; i++) begin
         @(negedge clk);
         check_eq("out_valid_held", out_valid, 1'b1);
         check_eq("sum_held", sum, es);
         check_eq("co_held", co, eco);
         check_eq("in_ready_done", in_ready, 1'b0);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check_eq("out_valid_after_take", out_valid, 1'b0);
      check_eq("in_ready_after_take", in_ready, 1'b1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      logic [8:0] full8;
      rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; ci = 1'b0; out_ready = 1'b0;
      in_valid2 = 1'b0; a2 = '0; b2 = '0; ci2 = 1'b0; out_ready2 = 1'b0;
      repeat (2) @(negedge clk);
      check_eq("rst_in_ready", in_ready, 1'b1);
      check_eq("rst_out_valid", out_valid, 1'b0);
      check_eq("rst_busy", busy, 1'b0);
      check_eq("rst_sum", sum, 16'h0000);
      check_eq("rst_co", co, 1'b0);
      rst = 1'b0;

      run_op(16'h0001, 16'h0002, 1'b0, 0);
      run_op(16'hFFFF, 16'h0001, 1'b0, 1);
      run_op(16'h7FFF, 16'h0001, 1'b0, 0);
      run_op(16'h1234, 16'h1111, 1'b1, 10);
      run_op(16'hFFFF, 16'h0000, 1'b1, 0);
      run_op(16'hFFFF, 16'hFFFF, 1'b1, 2);
      run_op(16'h8000, 16'h8000, 1'b0, 0);
      for (int i = 0; i < 25; i++) begin
         run_op(16'($urandom), 16'($urandom), 1'($urandom), $urandom_range(0, 3));
      end

      // Reset two cycles into an add: everything must clear at once
      in_valid = 1'b1; a = 16'hAAAA; b = 16'h5555; ci = 1'b0;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check_eq("midadd_rst_out_valid", out_valid, 1'b0);
      check_eq("midadd_rst_sum", sum, 16'h0000);
      check_eq("midadd_rst_busy", busy, 1'b0);
      check_eq("midadd_rst_in_ready", in_ready, 1'b1);
      @(negedge clk);
      rst = 1'b0;
      run_op(16'h0003, 16'h0004, 1'b1, 0);

      // Single-chunk instance: result one cycle after accept
      out_ready2 = 1'b1;
      for (int i = 0; i < 6; i++) begin
         if (i == 0) begin
            a2 = 8'hFF; b2 = 8'hFF; ci2 = 1'b1;
         end else begin
            a2 = 8'($urandom); b2 = 8'($urandom); ci2 = 1'($urandom);
         end
         full8 = {1'b0, a2} + {1'b0, b2} + {8'd0, ci2};
         check_eq("w8_in_ready", in_ready2, 1'b1);
         in_valid2 = 1'b1;
         @(negedge clk);
         in_valid2 = 1'b0;
         check_eq("w8_busy", busy2, 1'b1);
         @(negedge clk);
         check_eq("w8_out_valid", out_valid2, 1'b1);
         check_eq("w8_sum", sum2, full8[7:0]);
         check_eq("w8_co", co2, full8[8]);
`ifdef SERIAL_ADDER_OVF_EN
         check_eq("w8_ovf", ovf2, (a2[7] == b2[7]) && (full8[7] != a2[7]));
`endif
         @(negedge clk);
         check_eq("w8_in_ready_after", in_ready2, 1'b1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
